vga_timing: RTL and testbench



---
 rtl/vga_timing.sv | 126 ++++++++++++
 tb/tb_vga_timing.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: pixel-timing generator feeding the colour mixer stage.
// Keeps free-running line/frame counters and registers the visible window,
// active-low sync pulses, pixel coordinates and line/frame start pulses.
// Every output describes the same pixel and lags the counters by one enabled cycle.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset (overrides pix_en)
//   pix_en      pixel clock enable; one pixel advances per enabled cycle
//   active      1 inside the visible window
//   vga_hs      horizontal sync, active low
//   vga_vs      vertical sync, active low
//   x, y        pixel column / row (keep counting through blanking)
//   line_start  one-cycle pulse at hcnt=0
//   frame_start one-cycle pulse at pixel (0,0)
module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       active,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Region boundaries, pre-sized to the counter width.
  localparam logic [CW-1:0] H_VIS_END = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_FIRST  = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST   = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST  = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST   = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          active_q, active_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Next-state: outputs decode the current counters, counters step in the same cycle.
  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    active_d      = active_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    x_d           = x_q;
    y_d           = y_q;
    // Pulses drop on idle cycles so each lasts exactly one clk.
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_en) begin
      active_d      = (hcnt_q < H_VIS_END) && (vcnt_q < V_VIS_END);
      hs_d          = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
      vs_d          = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
      x_d           = hcnt_q;
      y_d           = vcnt_q;
      line_start_d  = (hcnt_q == '0);
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);

      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
      end else begin
        hcnt_d = hcnt_q + CW'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      active_q      <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      active_q      <= active_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign active      = active_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing using a shrunk timing set so several full
// frames fit in a short run. The reference tracks a linear pixel index within
// the frame and derives row/column and region membership arithmetically.
module tb_vga_timing;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VV = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic       active;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic       active;
  logic       vga_hs;
  logic       vga_vs;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;

  exp_t exp_q[$];
  exp_t model_out;
  int   pos;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic done     = 1'b0;

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .active     (active),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .x          (x),
    .y          (y),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue what the outputs must show after the edge.
  task automatic drive(input logic r, input logic e);
    int h;
    int v;
    @(negedge clk);
    reset  = r;
    pix_en = e;
    if (r) begin
      pos       = 0;
      model_out = '{active: 1'b0, hs: 1'b1, vs: 1'b1, x: 10'd0, y: 10'd0, ls: 1'b0, fs: 1'b0};
    end else if (e) begin
      h = pos % HT;
      v = pos / HT;
      model_out.active = (h < HV) && (v < VV);
      model_out.hs     = !((h >= HV + HF) && (h < HV + HF + HS));
      model_out.vs     = !((v >= VV + VF) && (v < VV + VF + VS));
      model_out.x      = 10'(h);
      model_out.y      = 10'(v);
      model_out.ls     = (h == 0);
      model_out.fs     = (pos == 0);
      pos = (pos + 1) % FRAME;
    end else begin
      model_out.ls = 1'b0;
      model_out.fs = 1'b0;
    end
    exp_q.push_back(model_out);
  endtask

  // Monitor: compares every registered output set against the queued expectation.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {active, vga_hs, vga_vs, x, y, line_start, frame_start};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL pixel cyc=%0d got act=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b want act=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b",
                   cyc, a.active, a.hs, a.vs, a.x, a.y, a.ls, a.fs,
                   e.active, e.hs, e.vs, e.x, e.y, e.ls, e.fs);
        end
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded time.
  initial begin
    #2000000;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: stimulus did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // Stimulus: reset, continuous run, half-rate enable, mid-frame reset, random mix.
  initial begin
    reset     = 1'b1;
    pix_en    = 1'b1;
    pos       = 0;
    model_out = '0;

    repeat (3) drive(1'b1, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (active !== 1'b0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 || x !== 10'd0 ||
        y !== 10'd0 || line_start !== 1'b0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset state: act=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b",
               active, vga_hs, vga_vs, x, y, line_start, frame_start);
    end

    for (int i = 0; i < 2 * FRAME + 3; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 2 * FRAME; i++) drive(1'b0, (i % 2) == 0);

    // Land mid-frame with continuous enable, then pulse reset for one cycle.
    while (pos != HT * 3 + 5) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    for (int i = 0; i < FRAME + 10; i++) drive(1'b0, 1'b1);

    // Reset asserted while enable is low must still clear everything.
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);

    for (int i = 0; i < 4000; i++)
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0));

    repeat (3) @(negedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
